// File: rtl/loader_pkg.sv
// Shared constants and FSM state encoding for the UART program loader.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam int         ADDR_W    = 16;
    localparam int         WORD_W    = 16;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR_H = 4'd1,
        ST_ADDR_L = 4'd2,
        ST_LEN    = 4'd3,
        ST_DLO    = 4'd4,
        ST_DHI    = 4'd5,
        ST_WR0    = 4'd6,
        ST_WR1    = 4'd7,
        ST_CHK    = 4'd8
    } loader_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, LSB-first shift.
// byte_valid / frame_err are single-cycle strobes with no back-pressure; byte_data is stable while byte_valid is high.
module uart_rx_byte #(
    parameter int unsigned BIT_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned     CW      = $clog2(BIT_DIV + 1);
    localparam logic [CW-1:0]   HALF_M1 = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0]   FULL_M1 = CW'(BIT_DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: parses SYNC/ADDR/LEN/words/CHK frames into program-memory writes.
// Optional macro LOADER_TIMEOUT_EN adds a mid-frame idle timeout of TIMEOUT_CYC cycles.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [WORD_W-1:0] prog_data,
    output logic [ADDR_W-1:0] prog_add,
    output logic              prog_we,
    output logic              prog_clk,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output loader_state_e     dbg_state
);

    localparam int unsigned BIT_DIV = CLK_HZ / BAUD;

    if (BIT_DIV < 4 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32'h00FF_FFFF) begin : g_cfg_check
        $error("uart_prog_loader: BIT_DIV must be >= 4 and TIMEOUT_CYC must fit 24 bits");
    end

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;

    uart_rx_byte #(.BIT_DIV(BIT_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] prog_add_q, prog_add_d;
    logic [WORD_W-1:0] prog_data_q, prog_data_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        chk_sum;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_TIMEOUT_EN
    logic [23:0]       idle_q, idle_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            prog_add_q  <= '0;
            prog_data_q <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            sum_q       <= '0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            prog_add_q  <= prog_add_d;
            prog_data_q <= prog_data_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            sum_q       <= sum_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef LOADER_TIMEOUT_EN
            idle_q      <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        prog_add_d  = prog_add_q;
        prog_data_d = prog_data_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        sum_d       = sum_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
        err_d       = err_q;
        chk_sum     = sum_q + byte_data;

        if (byte_valid && state_q != ST_IDLE) sum_d = chk_sum;

        case (state_q)
            ST_IDLE: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_d = ST_ADDR_H;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    sum_d   = '0;
                end
            end
            ST_ADDR_H: if (byte_valid) begin
                addr_d[15:8] = byte_data;
                state_d      = ST_ADDR_L;
            end
            ST_ADDR_L: if (byte_valid) begin
                addr_d[7:0] = byte_data;
                state_d     = ST_LEN;
            end
            ST_LEN: if (byte_valid) begin
                // LEN byte 0 encodes a full 256-word block.
                cnt_d   = {byte_data == 8'h00, byte_data};
                state_d = ST_DLO;
            end
            ST_DLO: if (byte_valid) begin
                lo_d    = byte_data;
                state_d = ST_DHI;
            end
            ST_DHI: if (byte_valid) begin
                prog_data_d = {byte_data, lo_q};
                prog_add_d  = addr_q;
                state_d     = ST_WR0;
            end
            ST_WR0: state_d = ST_WR1;
            ST_WR1: begin
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 9'd1;
                state_d = (cnt_q == 9'd1) ? ST_CHK : ST_DLO;
            end
            ST_CHK: if (byte_valid) begin
                done_d  = (chk_sum == 8'h00);
                err_d   = (chk_sum != 8'h00) | err_q;
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_err) begin
            err_d   = 1'b1;
            hold_d  = 1'b0;
            done_d  = 1'b0;
            state_d = ST_IDLE;
        end

`ifdef LOADER_TIMEOUT_EN
        // idle_q counts cycles since the last accepted byte.
        if (state_q == ST_IDLE && !byte_valid) idle_d = '0;
        else if (byte_valid)                   idle_d = 24'd1;
        else                                   idle_d = idle_q + 24'd1;
        if (state_q != ST_IDLE && !byte_valid && idle_q == 24'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_IDLE;
        end
`endif
    end

    assign prog_data = prog_data_q;
    assign prog_add  = prog_add_q;
    assign prog_we   = (state_q == ST_WR0) || (state_q == ST_WR1);
    assign prog_clk  = (state_q == ST_WR1);
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: bit-banged UART frames, write/frame-end scoreboard.
module tb_uart_prog_loader;
    import loader_pkg::*;

    localparam int BIT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [15:0]   prog_data;
    logic [15:0]   prog_add;
    logic          prog_we;
    logic          prog_clk;
    logic          cpu_hold;
    logic          done;
    logic          err;
    loader_state_e dbg_state;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];   // expected writes {addr, data}
    logic [1:0]  ev_q[$];    // expected {done, err} at each frame end

    uart_prog_loader #(
        .CLK_HZ      (1600000),
        .BAUD        (100000),
        .TIMEOUT_CYC (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .prog_data (prog_data),
        .prog_add  (prog_add),
        .prog_we   (prog_we),
        .prog_clk  (prog_clk),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(posedge clk);
        rx = 1'b1;
        repeat (BIT) @(posedge clk);
    endtask

    // Bytes are sent most-significant first out of the packed vector.
    task automatic send_bytes(input logic [95:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data_add"}, {prog_add, prog_data}, 32'h0);
        check({name, "_we_clk_hold_done_err"}, {27'b0, prog_we, prog_clk, cpu_hold, done, err}, 32'h0);
        check({name, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Monitor: pops expected writes and frame-end results as the DUT presents them.
    initial begin : monitor
        logic        we_prev, hold_prev;
        int          we_len;
        logic [31:0] cur;
        logic [1:0]  ev;
        we_prev = 1'b0; hold_prev = 1'b0; we_len = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                we_prev = 1'b0; hold_prev = 1'b0; we_len = 0;
                continue;
            end
            if (prog_we) begin
                if (!we_prev) begin
                    check("write_pending", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("write_addr_data", {prog_add, prog_data}, cur);
                    end
                    check("wr0_prog_clk", {31'b0, prog_clk}, 32'd0);
                    we_len = 1;
                end else begin
                    we_len++;
                    check("wr1_prog_clk", {31'b0, prog_clk}, 32'd1);
                    check("wr1_stable", {prog_add, prog_data}, cur);
                end
            end else begin
                if (we_prev) check("we_len", we_len, 2);
                if (prog_clk) check("clk_without_we", {31'b0, prog_clk}, 32'd0);
            end
            if (hold_prev && !cpu_hold) begin
                check("frame_end_pending", {31'b0, ev_q.size() != 0}, 32'd1);
                if (ev_q.size() != 0) begin
                    ev = ev_q.pop_front();
                    check("frame_end_done_err", {30'b0, done, err}, {30'b0, ev});
                end
            end else if (done) begin
                check("done_stray", {31'b0, done}, 32'd0);
            end
            we_prev   = prog_we;
            hold_prev = cpu_hold;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // 1: two words at 0x0100; checksum is the two's complement of the byte sum (0x17 -> 0xE9).
        exp_q.push_back({16'h0100, 16'h1234});
        exp_q.push_back({16'h0101, 16'h5678});
        ev_q.push_back(2'b10);
        send_bytes(96'h55, 1);
        check("t1_hold_after_sync", {31'b0, cpu_hold}, 32'd1);
        check("t1_state_after_sync", 32'(dbg_state), 32'(ST_ADDR_H));
        send_bytes(96'h01_00_02_34_12_78_56_E9, 8);
        check("t1_hold_err", {30'b0, cpu_hold, err}, 32'd0);
        check("t1_writes_drained", exp_q.size(), 0);
        check("t1_last_write_held", {prog_add, prog_data}, {16'h0101, 16'h5678});

        // 2: same frame, checksum off by one.
        exp_q.push_back({16'h0100, 16'h1234});
        exp_q.push_back({16'h0101, 16'h5678});
        ev_q.push_back(2'b01);
        send_bytes(96'h55_01_00_02_34_12_78_56_EA, 9);
        check("t2_hold_err_done", {29'b0, cpu_hold, err, done}, 32'b010);

        // 3: address wrap 0xFFFF -> 0x0000; byte sum 0xFE -> CHK 0x02.
        exp_q.push_back({16'hFFFF, 16'hAAAA});
        exp_q.push_back({16'h0000, 16'h5555});
        ev_q.push_back(2'b10);
        send_bytes(96'h55, 1);
        check("t3_err_cleared_by_sync", {31'b0, err}, 32'd0);
        send_bytes(96'hFF_FF_02_AA_AA_55_55_02, 8);
        check("t3_hold_err", {30'b0, cpu_hold, err}, 32'd0);
        check("t3_writes_drained", exp_q.size(), 0);

        // 4: SYNC with a bad stop bit, then a good single-word frame (sum 0xCE -> CHK 0x32).
        send_byte(8'h55, 1'b0);
        @(negedge clk);
        check("t4_framing_err", {31'b0, err}, 32'd1);
        check("t4_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("t4_hold_low", {31'b0, cpu_hold}, 32'd0);
        exp_q.push_back({16'h0020, 16'hBEEF});
        ev_q.push_back(2'b10);
        send_bytes(96'h55, 1);
        check("t4_err_cleared", {31'b0, err}, 32'd0);
        send_bytes(96'h00_20_01_EF_BE_32, 6);
        check("t4_hold_err", {30'b0, cpu_hold, err}, 32'd0);

        // 5: reset while the second word's high byte is on the line.
        exp_q.push_back({16'h0100, 16'h1234});
        send_bytes(96'h55_01_00_02_34_12_78, 7);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0] ^ i[1];
            repeat (BIT) @(posedge clk);
        end
        @(negedge clk);
        check("t5_state_dhi", 32'(dbg_state), 32'(ST_DHI));
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check_all_zero("t5_reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_only_first_word", exp_q.size(), 0);
        send_bytes(96'h00_FF, 2);
        check_all_zero("t5_idle_bytes");

        // 6: stalled frame after 55 00 10.
        send_bytes(96'h55_00, 2);
`ifdef LOADER_TIMEOUT_EN
        ev_q.push_back(2'b01);
        fork
            send_byte(8'h10);
            begin : watch
                int k;
                int n;
                k = 0;
                while (!dut.byte_valid && k < 400) begin
                    @(negedge clk);
                    k++;
                end
                check("t6_byte_seen", {31'b0, dut.byte_valid}, 32'd1);
                n = 0;
                while (!err && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                check("t6_timeout_cycles", n, 1000);
                check("t6_hold_low", {31'b0, cpu_hold}, 32'd0);
            end
        join
`else
        send_bytes(96'h10, 1);
        repeat (1500) @(negedge clk);
        check("t6_hold_stays", {31'b0, cpu_hold}, 32'd1);
        check("t6_no_err", {31'b0, err}, 32'd0);
        check("t6_state_len", 32'(dbg_state), 32'(ST_LEN));
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("t6_after_reset");

        check("end_writes_drained", exp_q.size(), 0);
        check("end_frames_drained", ev_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
